router_input_parser: RTL and testbench

Router ingress stage directly downstream of the packet transmitter. It accepts the transmitter's byte stream (srcid, dstid, size, payload, CRC) and checks the framing and the XOR CRC. A good packet is buffered whole and forwarded to one of three output ports selected by dstid; a bad packet is dropped and counted. It back-pressures the transmitter between packets through `rx_stop`.

---
 rtl/router_pkg.sv | 43 ++++
 rtl/pkt_buffer.sv | 36 +++
 rtl/router_input_parser.sv | 229 ++++++++++++++++++++++
 tb/tb_router_input_parser.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router ingress parser: port count, payload limit,
// header byte offsets inside a buffered packet, parser states, drop causes and
// a saturating increment helper for the drop counter.
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_PORTS   = 3;
  localparam int MAX_PAYLOAD = 7;

  // Byte offsets of the header fields inside a buffered packet.
  localparam int OFF_SRC  = 0;
  localparam int OFF_DST  = 1;
  localparam int OFF_SIZE = 2;
  localparam int OFF_DATA = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC,
    ST_DST,
    ST_SIZE,
    ST_DATA,
    ST_CRC,
    ST_SEND,
    ST_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SIZE    = 3'd1,
    ERR_FRAME   = 3'd2,
    ERR_CRC     = 3'd3,
    ERR_DST     = 3'd4,
    ERR_RESTART = 3'd5,
    ERR_OVERRUN = 3'd6
  } err_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_buffer.sv
// -----------------------------------------------------------------------------
// pkt_buffer
// DEPTH x 8 register file holding one packet. Synchronous write, asynchronous
// read.
//   clk      : clock
//   wr_en    : write wr_data at wr_ptr on the rising edge
//   wr_ptr   : write address
//   wr_data  : write byte
//   rd_ptr   : read address
//   rd_data  : byte at rd_ptr (combinational)
// -----------------------------------------------------------------------------
module pkt_buffer #(
  parameter int DEPTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; every entry is written before the
  // parser ever reads it, so clearing it would only cost a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/router_input_parser.sv
// -----------------------------------------------------------------------------
// router_input_parser
// Router ingress stage. Parses the transmitter byte stream (srcid, dstid,
// size, payload, CRC), checks framing and the XOR CRC over the payload,
// buffers a good packet and forwards it unchanged to the port given by dstid.
// Bad packets are dropped with a cause code and a saturating drop count.
//   clk, rst        : clock, asynchronous active-low reset
//   rx_data/valid   : ingress byte and its qualifier
//   rx_start/rx_end : first (srcid) / last (CRC) byte markers
//   rx_stop         : back-pressure to the transmitter while forwarding
//   out_data/last   : forwarded byte, high on the CRC byte
//   out_valid       : one-hot port select, out_ready per-port accept
//   pkt_ok/pkt_err  : one-cycle accept / drop pulses
//   err_code        : cause of the most recent drop
//   err_count       : saturating drop counter
// -----------------------------------------------------------------------------
module router_input_parser
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_start,
  input  logic                 rx_end,
  output logic                 rx_stop,
  output logic [7:0]           out_data,
  output logic [NUM_PORTS-1:0] out_valid,
  output logic                 out_last,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic                 pkt_ok,
  output logic                 pkt_err,
  output logic [2:0]           err_code,
  output logic [7:0]           err_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  state_e               state_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [7:0]           crc_q;
  logic [7:0]           dst_q;
  logic [2:0]           size_q;
  logic [NUM_PORTS-1:0] out_valid_q;
  logic                 pkt_ok_q;
  logic                 pkt_err_q;
  err_e                 err_code_q;
  logic [7:0]           err_count_q;

  logic                 buf_wr_en;
  logic [PTR_W-1:0]     buf_wr_ptr;
  logic [7:0]           buf_rd_data;
  logic [NUM_PORTS-1:0] dst_onehot;
  logic [PTR_W-1:0]     last_data_idx;
  logic [PTR_W-1:0]     last_pkt_idx;
  logic                 out_accept;

  // Every byte the receive states see is stored; a restart byte always lands
  // at the srcid slot because it begins a new packet.
  // NOTE: each always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    buf_wr_en  = 1'b0;
    buf_wr_ptr = rx_start ? PTR_W'(OFF_SRC) : wr_ptr_q;
    unique case (state_q)
      ST_IDLE:                          buf_wr_en = rx_valid && rx_start;
      ST_DST, ST_SIZE, ST_DATA, ST_CRC: buf_wr_en = rx_valid;
      default:                          buf_wr_en = 1'b0;
    endcase
  end

  always_comb begin
    dst_onehot = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dst_onehot[p] = (dst_q == 8'(p));
    end
  end

  assign last_data_idx = PTR_W'(OFF_DATA - 1) + PTR_W'(size_q);
  assign last_pkt_idx  = PTR_W'(OFF_DATA) + PTR_W'(size_q);
  // out_valid_q is one-hot on dst, so this is out_ready[dst] while forwarding.
  assign out_accept    = |(out_valid_q & out_ready);

  pkt_buffer #(.DEPTH(BUF_DEPTH), .AW(PTR_W)) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_ptr  (buf_wr_ptr),
    .wr_data (rx_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (buf_rd_data)
  );

  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values; blocking assignments would make the order of statements
  // change the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      crc_q       <= '0;
      dst_q       <= '0;
      size_q      <= '0;
      out_valid_q <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_start) begin
            wr_ptr_q <= PTR_W'(OFF_DST);
            crc_q    <= '0;
            state_q  <= ST_DST;
          end
        end

        ST_DST, ST_SIZE, ST_DATA, ST_CRC: begin
          if (rx_valid) begin
            if (rx_start) begin
              // Drop the current packet and treat this byte as a new srcid.
              pkt_err_q   <= 1'b1;
              err_code_q  <= ERR_RESTART;
              err_count_q <= sat_inc(err_count_q);
              wr_ptr_q    <= PTR_W'(OFF_DST);
              crc_q       <= '0;
              state_q     <= ST_DST;
            end else if (rx_end && state_q != ST_CRC) begin
              pkt_err_q   <= 1'b1;
              err_code_q  <= ERR_FRAME;
              err_count_q <= sat_inc(err_count_q);
              state_q     <= ST_IDLE;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              unique case (state_q)
                ST_DST: begin
                  dst_q   <= rx_data;
                  state_q <= ST_SIZE;
                end
                ST_SIZE: begin
                  size_q <= rx_data[2:0];
                  if (rx_data == 8'd0 || rx_data > 8'(MAX_PAYLOAD)) begin
                    pkt_err_q   <= 1'b1;
                    err_code_q  <= ERR_SIZE;
                    err_count_q <= sat_inc(err_count_q);
                    state_q     <= ST_DRAIN;
                  end else begin
                    state_q <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  crc_q <= crc_q ^ rx_data;
                  if (wr_ptr_q == last_data_idx) begin
                    state_q <= ST_CRC;
                  end
                end
                default: begin  // ST_CRC
                  if (!rx_end) begin
                    pkt_err_q   <= 1'b1;
                    err_code_q  <= ERR_FRAME;
                    err_count_q <= sat_inc(err_count_q);
                    state_q     <= ST_DRAIN;
                  end else if (rx_data != crc_q) begin
                    pkt_err_q   <= 1'b1;
                    err_code_q  <= ERR_CRC;
                    err_count_q <= sat_inc(err_count_q);
                    state_q     <= ST_IDLE;
                  end else if (dst_q >= 8'(NUM_PORTS)) begin
                    pkt_err_q   <= 1'b1;
                    err_code_q  <= ERR_DST;
                    err_count_q <= sat_inc(err_count_q);
                    state_q     <= ST_IDLE;
                  end else begin
                    pkt_ok_q    <= 1'b1;
                    rd_ptr_q    <= '0;
                    out_valid_q <= dst_onehot;
                    state_q     <= ST_SEND;
                  end
                end
              endcase
            end
          end
        end

        ST_SEND: begin
          // Ingress bytes are discarded here; a new packet start is an overrun.
          if (rx_valid && rx_start) begin
            pkt_err_q   <= 1'b1;
            err_code_q  <= ERR_OVERRUN;
            err_count_q <= sat_inc(err_count_q);
          end
          if (out_accept) begin
            if (rd_ptr_q == last_pkt_idx) begin
              rd_ptr_q    <= '0;
              out_valid_q <= '0;
              state_q     <= ST_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (rx_valid && rx_end) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_stop   = (state_q == ST_SEND);
  assign out_valid = out_valid_q;
  assign out_data  = (state_q == ST_SEND) ? buf_rd_data : 8'h00;
  assign out_last  = (state_q == ST_SEND) && (rd_ptr_q == last_pkt_idx);
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_router_input_parser.sv
// -----------------------------------------------------------------------------
// tb_router_input_parser
// Directed bench for router_input_parser: good packet, CRC/DST/SIZE drops,
// back-pressure with an overrun, restart, and reset during forwarding.
// Expected bytes and codes are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_router_input_parser;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_start;
  logic       rx_end;
  logic       rx_stop;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic       out_last;
  logic [2:0] out_ready;
  logic       pkt_ok;
  logic       pkt_err;
  logic [2:0] err_code;
  logic [7:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Written only by the monitor; tests take snapshots.
  int         stop_cycles = 0;
  int         ov_cycles   = 0;
  logic [7:0] cap_data [$];
  logic [2:0] cap_port [$];
  logic       cap_last [$];

  logic [7:0] exp_q [$];

  router_input_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_start  (rx_start),
    .rx_end    (rx_end),
    .rx_stop   (rx_stop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample on the falling edge; a byte offered with ready is taken next rise.
  always @(negedge clk) begin
    if (rx_stop) stop_cycles++;
    if (|out_valid) ov_cycles++;
    if (|(out_valid & out_ready)) begin
      cap_data.push_back(out_data);
      cap_port.push_back(out_valid);
      cap_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_start = s;
    rx_end   = e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_start = 1'b0;
    rx_end   = 1'b0;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < exp_q.size(); i++) begin
      send_byte(exp_q[i], i == 0, i == exp_q.size() - 1);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!rx_stop) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_done"}, rx_stop, 1'b0);
  endtask

  // Compares captured output bytes from index base against exp_q.
  task automatic check_fwd(input string tag, input int base, input logic [2:0] port);
    check({tag, "_cnt"}, cap_data.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < cap_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), cap_data[base+i], exp_q[i]);
        check($sformatf("%s_port%0d", tag, i), cap_port[base+i], port);
        check($sformatf("%s_last%0d", tag, i), cap_last[base+i], i == exp_q.size() - 1);
      end
    end
  endtask

  initial begin
    int base;
    int sbase;
    int obase;
    int idx;

    rst       = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rx_start  = 1'b0;
    rx_end    = 1'b0;
    out_ready = 3'b111;
    #12;
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_rx_stop", rx_stop, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_err_code", err_code, 3'd0);
    check("rst_pkt_ok", pkt_ok, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: good packet to port 1
    base  = cap_data.size();
    sbase = stop_cycles;
    exp_q = '{8'h11, 8'h01, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00};
    send_pkt();
    check("t1_pkt_ok", pkt_ok, 1'b1);
    check("t1_out_valid", out_valid, 3'b010);
    check("t1_first", out_data, 8'h11);
    check("t1_rx_stop", rx_stop, 1'b1);
    wait_done("t1");
    check("t1_stop_cycles", stop_cycles - sbase, 7);
    check_fwd("t1", base, 3'b010);

    // T2: bad CRC
    obase = ov_cycles;
    exp_q = '{8'h11, 8'h01, 8'h03, 8'h01, 8'h02, 8'h03, 8'h05};
    send_pkt();
    check("t2_pkt_err", pkt_err, 1'b1);
    check("t2_err_code", err_code, 3'd3);
    check("t2_err_count", err_count, 8'd1);
    @(posedge clk);
    #1;
    check("t2_pkt_err_pulse", pkt_err, 1'b0);
    check("t2_no_valid", ov_cycles - obase, 0);

    // T3: dstid out of range with a good CRC
    obase = ov_cycles;
    exp_q = '{8'h11, 8'h03, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00};
    send_pkt();
    check("t3_err_code", err_code, 3'd4);
    check("t3_err_count", err_count, 8'd2);
    @(posedge clk);
    #1;
    check("t3_no_valid", ov_cycles - obase, 0);

    // T4: size 0 -> drain until rx_end, then a good packet to port 0
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    check("t4_pkt_err", pkt_err, 1'b1);
    check("t4_err_code", err_code, 3'd1);
    check("t4_err_count", err_count, 8'd3);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    check("t4_drain_quiet", pkt_err, 1'b0);
    check("t4_drain_count", err_count, 8'd3);
    base  = cap_data.size();
    exp_q = '{8'h22, 8'h00, 8'h01, 8'hAA, 8'hAA};
    send_pkt();
    check("t4_pkt_ok", pkt_ok, 1'b1);
    check("t4_out_valid", out_valid, 3'b001);
    wait_done("t4");
    check_fwd("t4", base, 3'b001);

    // T5: port 1 ready every other cycle, second packet start during SEND
    base      = cap_data.size();
    out_ready = 3'b101;
    exp_q     = '{8'h33, 8'h01, 8'h02, 8'h05, 8'h06, 8'h03};
    send_pkt();
    check("t5_pkt_ok", pkt_ok, 1'b1);
    idx = 0;
    for (int k = 0; k < 40; k++) begin
      if (!rx_stop) break;
      check($sformatf("t5_hold%0d", k), out_data, exp_q[idx]);
      out_ready = k[0] ? 3'b111 : 3'b101;
      if (k == 2) begin
        rx_valid = 1'b1; rx_start = 1'b1; rx_data = 8'h44;
      end else if (k == 3) begin
        rx_valid = 1'b1; rx_data = 8'h01;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_start = 1'b0;
      if (out_ready[1]) idx++;
      if (k == 2) begin
        check("t5_overrun_pulse", pkt_err, 1'b1);
        check("t5_overrun_code", err_code, 3'd6);
      end
    end
    out_ready = 3'b111;
    check("t5_done", rx_stop, 1'b0);
    check("t5_err_count", err_count, 8'd4);
    check_fwd("t5", base, 3'b010);

    // T6: rx_start on the 2nd data byte restarts parsing
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    base = cap_data.size();
    send_byte(8'h66, 1'b1, 1'b0);
    check("t6_pkt_err", pkt_err, 1'b1);
    check("t6_err_code", err_code, 3'd5);
    check("t6_err_count", err_count, 8'd5);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b0, 1'b1);
    check("t6_pkt_ok", pkt_ok, 1'b1);
    check("t6_out_valid", out_valid, 3'b100);
    wait_done("t6");
    exp_q = '{8'h66, 8'h02, 8'h01, 8'h7E, 8'h7E};
    check_fwd("t6", base, 3'b100);

    // T7: reset while the 3rd byte is being forwarded
    exp_q = '{8'h77, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
    send_pkt();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t7_third_byte", out_data, 8'h02);
    #2;
    rst = 1'b0;
    #1;
    check("t7_rst_valid", out_valid, 3'b000);
    check("t7_rst_data", out_data, 8'h00);
    check("t7_rst_last", out_last, 1'b0);
    check("t7_rst_stop", rx_stop, 1'b0);
    check("t7_rst_err_pulse", pkt_err, 1'b0);
    check("t7_rst_count", err_count, 8'd0);
    check("t7_rst_code", err_code, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    base  = cap_data.size();
    exp_q = '{8'h88, 8'h00, 8'h01, 8'h5A, 8'h5A};
    send_pkt();
    check("t7_pkt_ok", pkt_ok, 1'b1);
    check("t7_out_valid", out_valid, 3'b001);
    wait_done("t7");
    check_fwd("t7", base, 3'b001);
    check("t7_err_count", err_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
